data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the processor's stalling data-memory request interface.
- The requester drives Rd/Wr, Addr and DataIn. This block answers with Stall, Done, DataOut, CacheHit and err.
- Internally it is a word-organised data array behind a one-entry line tag, so responses have variable latency: short on a hit, MISS_LAT cycles on a miss.
- It sits behind the memory stage and serves as the timing-accurate data memory for the pipeline and its benches.

Parameters:
- DEPTH_WORDS, 256: number of 16-bit words in the array. The word index is Addr[15:1] modulo DEPTH_WORDS, so addresses wrap.
- MISS_LAT, 4: number of BUSY cycles on a miss. Must be ≥1.
- OFFS_W, 3: byte-offset bits per line. The tag is Addr[15:OFFS_W].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; state resets on a clk edge while rst=0.
- Rd  input  1  read request.
- Wr  input  1  write request.
- Addr  input  16  byte address; must be even.
- DataIn  input  16  write data.
- DataOut  output  16  read data; valid only while Done=1.
- Stall  output  1  requester must hold Rd/Wr/Addr/DataIn stable while this is 1.
- Done  output  1  single-cycle completion pulse.
- CacheHit  output  1  qualifies Done: 1 if the access hit the line tag.
- err  output  1  illegal request (unaligned, or Rd and Wr together).

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, tag_valid=0, counter=0, DataOut=0.
  - Done=0, CacheHit=0, Stall=0, err=0.
  - Array contents are not cleared.
  - Reset mid-BUSY aborts the access: no write is committed and no Done is issued.
- States: IDLE, BUSY, DONE.
- Legal request, in IDLE: (Rd xor Wr) and Addr[0]=0.
- Illegal request, in IDLE: (Rd&Wr), or (Rd|Wr) with Addr[0]=1.
  - err=1 combinationally in that cycle; Stall=0, Done=0.
  - No state change, no array access.
- IDLE with a legal request:
  - Stall=1 combinationally.
  - Latch op, Addr and DataIn at the edge.
  - Hit (tag_valid and Addr[15:OFFS_W]==tag): next state DONE, hit_flag=1.
  - Miss: next state BUSY, counter=MISS_LAT-1, hit_flag=0.
- BUSY:
  - Stall=1.
  - Counter decrements each edge; when counter==0 at an edge, next state DONE.
  - Miss latency: request in cycle 0, BUSY in cycles 1..MISS_LAT, DONE in cycle MISS_LAT+1.
  - Hit latency: DONE in cycle 1.
- Entering DONE (same edge):
  - Write: array[idx] <= latched DataIn.
  - Read: DataOut <= array[idx].
  - Tag update: tag <= latched Addr[15:OFFS_W], tag_valid=1 (read and write alike).
- DONE:
  - Done=1, Stall=0, CacheHit=hit_flag.
  - DataOut holds read data; it is 0 for writes.
  - Next state is always IDLE.
  - Request inputs in this cycle are ignored, because the requester is retiring the current access.
- Outside DONE: Done=0, CacheHit=0, DataOut=0.
- Back-to-back: a new request may be presented in the cycle after DONE (IDLE). Throughput is 1 access per 2 cycles on hits.
- Read-after-write to the same word returns the new data, since the write commits on entry to DONE.
- Request inputs changing while Stall=1 are ignored; the latched copy is used.

Test Plan:
- Reset, then Rd Addr=0x0010 (cold miss, MISS_LAT=4):
  - Stall=1 in cycles 0–4.
  - Done=1, CacheHit=0 in cycle 5.
  - DataOut equals preloaded word 8.
- Wr Addr=0x0012 DataIn=0xBEEF after the previous access:
  - Tag 0x0010>>3 matches, so Done in cycle 1 with CacheHit=1.
  - A following Rd 0x0012 hits and returns 0xBEEF, CacheHit=1.
- Rd Addr=0x0021 → err=1, Stall=0, no Done, state stays IDLE.
- Rd=Wr=1 at Addr 0x0004 → err=1, Stall=0, no Done, state stays IDLE.
- Wr 0x0040=0x1234 miss; assert rst=0 in the second BUSY cycle:
  - No Done is issued.
  - After release, Rd 0x0040 is a miss (tag_valid cleared) and returns the pre-test value, not 0x1234.
- Wr 0x0002=0xAAAA, then Wr 0x0202=0x5555 with DEPTH_WORDS=256:
  - Both addresses alias to word 1.
  - Rd 0x0002 returns 0x5555 via a miss path (tags differ).
  - Verify Stall/Done timing matches MISS_LAT.

Source files
------------

// File: rtl/data_mem_responder.sv
// Stalling data-memory responder: word array behind a one-entry line tag.
// Done one cycle after a hit request, MISS_LAT+1 cycles after a miss; Stall holds the requester meanwhile.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int MISS_LAT    = 4,
  parameter int OFFS_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Stall,
  output logic        Done,
  output logic        CacheHit,
  output logic        err
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW   = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, nextState;
  logic [CW-1:0]     counter;
  logic              tagValid;
  logic [15:OFFS_W]  tag;
  logic              hitFlag;
  logic              latWr;
  logic [15:1]       latAddr;
  logic [15:0]       latData;
  logic [15:0]       dataOutQ;
  logic [15:0]       mem [DEPTH_WORDS];

  logic              legalReq, illegalReq, tagHit, enterDone;
  logic              accWr;
  logic [15:1]       accAddr;
  logic [15:0]       accData;
  logic [IDXW-1:0]   idx;

  assign legalReq   = (Rd ^ Wr) & ~Addr[0];
  assign illegalReq = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign tagHit     = tagValid && (Addr[15:OFFS_W] == tag);
  assign idx        = IDXW'({17'd0, accAddr} % 32'(DEPTH_WORDS));

  // A hit commits in the same edge the request is latched, so IDLE uses the live inputs.
  always_comb begin
    nextState = state;
    Stall     = 1'b0;
    err       = 1'b0;
    enterDone = 1'b0;
    accWr     = latWr;
    accAddr   = latAddr;
    accData   = latData;
    case (state)
      IDLE: begin
        accWr   = Wr;
        accAddr = Addr[15:1];
        accData = DataIn;
        err     = illegalReq;
        Stall   = legalReq;
        if (legalReq) begin
          if (tagHit) begin
            nextState = DONE;
            enterDone = 1'b1;
          end else begin
            nextState = BUSY;
          end
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (counter == '0) begin
          nextState = DONE;
          enterDone = 1'b1;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      counter  <= '0;
      tagValid <= 1'b0;
      tag      <= '0;
      hitFlag  <= 1'b0;
      latWr    <= 1'b0;
      latAddr  <= '0;
      latData  <= '0;
      dataOutQ <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && legalReq) begin
        latWr   <= Wr;
        latAddr <= Addr[15:1];
        latData <= DataIn;
        hitFlag <= tagHit;
        counter <= CW'(MISS_LAT - 1);
      end else if (state == BUSY && counter != '0) begin
        counter <= counter - 1'b1;
      end
      if (enterDone) begin
        tagValid <= 1'b1;
        tag      <= accAddr[15:OFFS_W];
        dataOutQ <= accWr ? 16'h0000 : mem[idx];
      end
    end
  end

  // Array is never cleared; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (rst && enterDone && accWr) mem[idx] <= accData;
  end

  assign Done     = (state == DONE);
  assign CacheHit = Done & hitFlag;
  assign DataOut  = Done ? dataOutQ : 16'h0000;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: driver pushes expectations, negedge monitor checks completions.
module tb_data_mem_responder;

  localparam int MISS_LAT = 4;
  localparam int LAT_MISS = MISS_LAT + 1;
  localparam int LAT_HIT  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Rd = 1'b0, Wr = 1'b0;
  logic [15:0] Addr = 16'h0000, DataIn = 16'h0000;
  logic [15:0] DataOut;
  logic        Stall, Done, CacheHit, err;

  typedef struct {
    logic [15:0] d;
    logic        h;
    int          s;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;
  int   stallCnt = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .MISS_LAT(MISS_LAT), .OFFS_W(3)) dut (
    .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
    .DataOut(DataOut), .Stall(Stall), .Done(Done), .CacheHit(CacheHit), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: counts Stall cycles per access and checks every Done against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stallCnt = 0;
      end else begin
        if (Stall) stallCnt++;
        if (Done) begin
          if (expQ.size() == 0) begin
            check("unexpected_done", 16'd1, 16'd0);
          end else begin
            e = expQ.pop_front();
            check("dataout", DataOut, e.d);
            check("cachehit", {15'd0, CacheHit}, {15'd0, e.h});
            check("stall_cycles", 16'(stallCnt), 16'(e.s));
          end
          stallCnt = 0;
        end else begin
          check("dataout_idle_zero", DataOut, 16'h0000);
        end
      end
    end
  end

  // Drive a legal access starting just after a rising edge; hold until Stall drops (DONE).
  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] din,
                        input logic [15:0] expD, input logic expH, input int expS);
    exp_t e;
    int   n;
    e.d = expD; e.h = expH; e.s = expS;
    expQ.push_back(e);
    Rd = rd; Wr = wr; Addr = a; DataIn = din;
    n = 0;
    forever begin
      @(negedge clk);
      if (!Stall) break;
      n++;
      if (n > 50) begin
        check("stall_timeout", 16'(n), 16'(expS));
        break;
      end
    end
    Rd = 1'b0; Wr = 1'b0; DataIn = 16'h0000;
    @(posedge clk); #1;
  endtask

  task automatic badReq(input string name, input logic rd, input logic wr, input logic [15:0] a);
    Rd = rd; Wr = wr; Addr = a;
    @(negedge clk);
    check({name, "_err"}, {15'd0, err}, 16'd1);
    check({name, "_stall"}, {15'd0, Stall}, 16'd0);
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    check({name, "_no_done"}, {15'd0, Done}, 16'd0);
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    doReset();
    // Seed array contents; a later reset leaves them intact.
    access(1'b0, 1'b1, 16'h0010, 16'h1111, 16'h0000, 1'b0, LAT_MISS);
    access(1'b0, 1'b1, 16'h0040, 16'h0C0C, 16'h0000, 1'b0, LAT_MISS);
    doReset();
    @(negedge clk);
    check("rst_stall", {15'd0, Stall}, 16'd0);
    check("rst_done", {15'd0, Done}, 16'd0);
    check("rst_hit", {15'd0, CacheHit}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_dataout", DataOut, 16'h0000);
    @(posedge clk); #1;

    access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1111, 1'b0, LAT_MISS);
    access(1'b0, 1'b1, 16'h0012, 16'hBEEF, 16'h0000, 1'b1, LAT_HIT);
    access(1'b1, 1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b1, LAT_HIT);

    badReq("unaligned", 1'b1, 1'b0, 16'h0021);
    badReq("rd_and_wr", 1'b1, 1'b1, 16'h0004);
    // Tag must be unchanged by the illegal requests.
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1111, 1'b1, LAT_HIT);

    // Reset in the second BUSY cycle of a write miss.
    Rd = 1'b0; Wr = 1'b1; Addr = 16'h0040; DataIn = 16'h1234;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; Wr = 1'b0; DataIn = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_stall", {15'd0, Stall}, 16'd0);
    check("abort_done", {15'd0, Done}, 16'd0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0C0C, 1'b0, LAT_MISS);

    // Aliasing: 0x0002 and 0x0202 share word 1 but carry different tags.
    access(1'b0, 1'b1, 16'h0002, 16'hAAAA, 16'h0000, 1'b0, LAT_MISS);
    access(1'b0, 1'b1, 16'h0202, 16'h5555, 16'h0000, 1'b0, LAT_MISS);
    access(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h5555, 1'b0, LAT_MISS);
    access(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h5555, 1'b1, LAT_HIT);

    repeat (3) @(posedge clk);
    check("queue_drained", 16'(expQ.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
